// File: rtl/driver_scan_sequencer.sv
// Scans a ROWS x COLS active/dot bit map onto NUM_CHANNELS parallel drivers, one position at a time.
// Optional DRIVER_SCAN_LOOP_EN: frames repeat continuously until abort instead of returning to idle.
module driver_scan_sequencer #(
  parameter int unsigned ROWS         = 48,
  parameter int unsigned COLS         = 48,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned MEM_ADDR_W   = 10,
  parameter int unsigned DWELL_W      = 8,
  localparam int unsigned CPC   = COLS / NUM_CHANNELS,
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned COL_W = (CPC > 1) ? $clog2(CPC) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MEM_ADDR_W-1:0]   mem_address,
  input  logic                    mem_write_n,
  input  logic [15:0]             data_in,
  input  logic                    start,
  input  logic                    abort,
  input  logic [DWELL_W-1:0]      dwell_cycles,
  output logic [NUM_CHANNELS-1:0] driver_data,
  output logic [NUM_CHANNELS-1:0] driver_enable,
  output logic                    busy,
  output logic                    done,
  output logic                    write_err,
  output logic [ROW_W-1:0]        cur_row,
  output logic [COL_W-1:0]        cur_col
);

  localparam int unsigned A         = ROWS * COLS / 16;
  localparam int unsigned MEM_WORDS = 2 * A;
  localparam int unsigned MA_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned IDX_W     = $clog2(ROWS * COLS) + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRIVE, S_DONE} state_t;

  state_t                  r_state;
  logic [15:0]             r_mem [MEM_WORDS];
  logic [ROW_W-1:0]        r_row;
  logic [COL_W-1:0]        r_col;
  logic [DWELL_W-1:0]      r_dwell;
  logic [DWELL_W-1:0]      r_cnt;
  logic [NUM_CHANNELS-1:0] r_en;
  logic [NUM_CHANNELS-1:0] r_data;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic [NUM_CHANNELS-1:0] w_act;
  logic [NUM_CHANNELS-1:0] w_dot;
  logic                    w_addr_ok;

  assign driver_data   = r_data;
  assign driver_enable = r_en;
  assign busy          = r_busy;
  assign done          = r_done;
  assign write_err     = r_err;
  assign cur_row       = r_row;
  assign cur_col       = r_col;

  assign w_addr_ok = {1'b0, mem_address} < (MEM_ADDR_W + 1)'(MEM_WORDS);

  // Channel k owns the column band starting at k*CPC; dot map sits A words above the active map.
  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    logic [IDX_W-1:0] w_idx;
    logic [MA_W-1:0]  w_word;
    assign w_idx    = IDX_W'(r_row) * IDX_W'(COLS) + IDX_W'(k * CPC) + IDX_W'(r_col);
    assign w_word   = MA_W'(w_idx >> 4);
    assign w_act[k] = r_mem[w_word][w_idx[3:0]];
    assign w_dot[k] = r_mem[MA_W'(A) + w_word][w_idx[3:0]];
  end

  always_ff @(posedge clock) begin
    if (!mem_write_n && !r_busy && w_addr_ok)
      r_mem[mem_address[MA_W-1:0]] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_dwell <= '0;
      r_cnt   <= '0;
      r_en    <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!mem_write_n && r_busy)
        r_err <= 1'b1;

      if (abort && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_en    <= '0;
        r_data  <= '0;
        r_busy  <= 1'b0;
        r_row   <= '0;
        r_col   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state <= S_LOAD;
              r_busy  <= 1'b1;
              r_row   <= '0;
              r_col   <= '0;
              r_dwell <= (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
            end
          end
          S_LOAD: begin
            r_en    <= w_act;
            r_data  <= w_act & w_dot;
            r_cnt   <= DWELL_W'(1);
            r_state <= S_DRIVE;
          end
          S_DRIVE: begin
            if (r_cnt >= r_dwell) begin
              r_en   <= '0;
              r_data <= '0;
              if (r_col == COL_W'(CPC - 1)) begin
                r_col <= '0;
                if (r_row == ROW_W'(ROWS - 1)) begin
                  r_row   <= '0;
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_row   <= r_row + 1'b1;
                  r_state <= S_LOAD;
                end
              end else begin
                r_col   <= r_col + 1'b1;
                r_state <= S_LOAD;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_DONE: begin
`ifdef DRIVER_SCAN_LOOP_EN
            r_state <= S_LOAD;
            r_row   <= '0;
            r_col   <= '0;
`else
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
`endif
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
